uart_config_sequencer: RTL and testbench
========================================

# uart_config_sequencer

Bus-master sequencer that programs the UART configuration register file through its 8-bit register port.

- On a single `start_i` pulse it writes, in a fixed order, the divisor, FIFO threshold, interrupt enables, control word and frame format.
- It then waits for the link-level configuration handshake to complete, as seen in the control register.
- It sits between the host/boot logic and the register file, replacing hand-coded register write sequences.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1024: maximum number of POLL cycles before the sequence is aborted with an error.

Ports (register-map addresses: STR=0, LDVR=1, UDVR=2, FSR=3, CTR=4, ISR=5):
- `clk_i`  in  1  system clock.
- `rst_n_i`  in  1  reset; asynchronous, active-low.
- `start_i`  in  1  start request, sampled only in IDLE.
- `use_std_i`  in  1  sampled with `start_i`; 1 = only request the standard configuration.
- `data_width_i`  in  2  frame data width (STR[1:0]).
- `parity_mode_i`  in  2  parity mode (STR[3:2]).
- `stop_bits_i`  in  2  stop bits (STR[5:4]).
- `dsm_i`  in  2  {tx, rx} data-stream mode (STR[7:6]).
- `divisor_i`  in  16  baud divisor.
- `rx_threshold_i`  in  6  RX FIFO threshold.
- `int_en_i`  in  4  {txdone/rxrdy, frame, parity, overrun} enables.
- `int_vec_en_i`  in  1  interrupt-vector enable (CTR bit 6 on write).
- `comm_mode_i`  in  2  communication mode (CTR[4:3] on write).
- `busy_o`  out  1  sequence in progress.
- `done_o`  out  1  one-cycle completion pulse.
- `error_o`  out  1  one-cycle pulse, coincident with `done_o`, on timeout.
- `bus_write_o`  out  1  register write strobe.
- `bus_read_o`  out  1  register read strobe.
- `bus_address_o`  out  3  register address.
- `bus_wdata_o`  out  8  write data.
- `bus_rdata_i`  in  8  read data, valid in the same cycle as `bus_read_o`.

## Operation
All configuration inputs are latched into internal registers at start. Later input changes have no effect on a running sequence.

States, one bus access per state:
- IDLE: on `start_i`, go to WR_STD if `use_std_i`=1, else RD_STR.
- RD_STR: read addr 0; capture `old_str` = `bus_rdata_i`.
- WR_LDVR: write addr 1, data `divisor[7:0]`.
- WR_UDVR: write addr 2, data `divisor[15:8]`. Must immediately follow WR_LDVR (the divisor-commit logic requires addresses 1 then 2 on consecutive cycles).
- WR_FSR: write addr 3, data `{2'b00, rx_threshold}`.
- WR_ISR: write addr 5, data `{1'b0, int_en, 3'b000}`.
- WR_CTR: write addr 4, data `{1'b0, int_vec_en, 1'b0, comm_mode, 1'b1, 2'b00}`. Bit 2 sets the enable-config-request bit.
- WR_STR: write addr 0, data `new_str` = `{dsm, stop, parity, width}`.
  - If `new_str[5:0] == old_str[5:0]`, go to FINISH.
  - Otherwise go to POLL_LO.
- POLL_LO: read addr 4 every cycle; go to POLL_HI when `bus_rdata_i[2]`=0 (negotiation started).
- POLL_HI: read addr 4 every cycle; go to FINISH when `bus_rdata_i[2]`=1.
- WR_STD: write addr 4, data 8'h02 (standard-config request); go to FINISH.
- FINISH: `done_o`=1, `busy_o`=0; next state IDLE.
- ERROR: `done_o`=1, `error_o`=1, `busy_o`=0; next state IDLE.

Rules:
- Timeout counter: cleared on leaving IDLE, increments each POLL_LO/POLL_HI cycle. POLL cycle number `TIMEOUT_CYCLES` goes to ERROR instead of continuing.
- `start_i` outside IDLE is ignored (no queuing). `start_i` held high restarts only after the IDLE cycle that follows FINISH/ERROR.
- The sequencer never reads or writes addresses 6/7 and never asserts read and write together.
- `bus_address_o` holds its last value when no strobe is asserted.

## Timing
- Reset values: state IDLE; `busy_o`=0, `done_o`=0, `error_o`=0, `bus_write_o`=0, `bus_read_o`=0, `bus_address_o`=3'd4, `bus_wdata_o`=0, timeout counter=0.
- All outputs are registered. If `start_i` is sampled at edge k, the RD_STR strobe is visible in cycle k+1. `busy_o` is high from cycle k+1 up to the cycle before `done_o`.
- No-change path: bus accesses in cycles k+1..k+7; `done_o` in cycle k+8.
- Negotiation path: `done_o` in the cycle after the POLL_HI cycle that samples bit 2 = 1.
- Standard path: write in cycle k+1; `done_o` in cycle k+2.
- Reset asserted mid-sequence: outputs return to reset values immediately; no partial write completes.

## Test plan
- Reset, then idle 10 cycles -> all outputs at reset values; no strobe.
- Start with width=3, parity=0, stop=0, dsm=0, divisor=0x0144; rdata=0x03 on RD_STR -> bus trace R0, W1=0x44, W2=0x01, W3, W5, W4, W0=0x03 in consecutive cycles; `done_o` at k+8; no poll.
- Same start with width=2 (old STR 0x03); CTR rdata bit2 = 1, 0, 0, 0, 1 -> two POLL_LO reads then POLL_HI; `done_o` one cycle after the final read; `error_o`=0.
- TIMEOUT_CYCLES=8, changed config, CTR bit2 stuck at 1 -> exactly 8 poll reads, then `done_o`=`error_o`=1 for one cycle.
- `use_std_i`=1 -> single W4=0x02, `done_o` at k+2; a second `start_i` pulse during busy is ignored.
- Assert `rst_n_i` during POLL_HI -> strobes drop immediately; a fresh start replays the full sequence from RD_STR.

Source files
------------

// File: rtl/uart_config_sequencer.sv
// uart_config_sequencer: programs the UART register file over its 8-bit
// register port, then waits for the link configuration handshake.
module uart_config_sequencer #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic        use_std_i,
    input  logic [1:0]  data_width_i,
    input  logic [1:0]  parity_mode_i,
    input  logic [1:0]  stop_bits_i,
    input  logic [1:0]  dsm_i,
    input  logic [15:0] divisor_i,
    input  logic [5:0]  rx_threshold_i,
    input  logic [3:0]  int_en_i,
    input  logic        int_vec_en_i,
    input  logic [1:0]  comm_mode_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic        bus_write_o,
    output logic        bus_read_o,
    output logic [2:0]  bus_address_o,
    output logic [7:0]  bus_wdata_o,
    input  logic [7:0]  bus_rdata_i
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_RD_STR  = 4'd1;
    localparam logic [3:0] S_WR_LDVR = 4'd2;
    localparam logic [3:0] S_WR_UDVR = 4'd3;
    localparam logic [3:0] S_WR_FSR  = 4'd4;
    localparam logic [3:0] S_WR_ISR  = 4'd5;
    localparam logic [3:0] S_WR_CTR  = 4'd6;
    localparam logic [3:0] S_WR_STR  = 4'd7;
    localparam logic [3:0] S_POLL_LO = 4'd8;
    localparam logic [3:0] S_POLL_HI = 4'd9;
    localparam logic [3:0] S_WR_STD  = 4'd10;
    localparam logic [3:0] S_FINISH  = 4'd11;
    localparam logic [3:0] S_ERROR   = 4'd12;

    logic [3:0]    state_q, state_d;
    logic [CW-1:0] tmo_q, tmo_d;
    logic [5:0]    old_str_q, old_str_d;
    logic [7:0]    str_q, str_d;
    logic [15:0]   div_q, div_d;
    logic [5:0]    thr_q, thr_d;
    logic [3:0]    ien_q, ien_d;
    logic          ive_q, ive_d;
    logic [1:0]    cmode_q, cmode_d;

    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          wr_q, wr_d;
    logic          rd_q, rd_d;
    logic [2:0]    addr_q, addr_d;
    logic [7:0]    wdata_q, wdata_d;

    // Only bit 2 of CTR and the low six bits of STR matter on reads.
    logic unused_rdata;
    assign unused_rdata = ^bus_rdata_i[7:6];

    // Next-state sequencing, then registered bus outputs decoded from
    // the state being entered so every strobe lines up with its state.
    always_comb begin
        state_d   = state_q;
        tmo_d     = tmo_q;
        old_str_d = old_str_q;
        str_d     = str_q;
        div_d     = div_q;
        thr_d     = thr_q;
        ien_d     = ien_q;
        ive_d     = ive_q;
        cmode_d   = cmode_q;
        wr_d      = 1'b0;
        rd_d      = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = use_std_i ? S_WR_STD : S_RD_STR;
                    tmo_d   = '0;
                    str_d   = {dsm_i, stop_bits_i, parity_mode_i, data_width_i};
                    div_d   = divisor_i;
                    thr_d   = rx_threshold_i;
                    ien_d   = int_en_i;
                    ive_d   = int_vec_en_i;
                    cmode_d = comm_mode_i;
                end
            end
            S_RD_STR: begin
                old_str_d = bus_rdata_i[5:0];
                state_d   = S_WR_LDVR;
            end
            S_WR_LDVR: state_d = S_WR_UDVR;
            S_WR_UDVR: state_d = S_WR_FSR;
            S_WR_FSR:  state_d = S_WR_ISR;
            S_WR_ISR:  state_d = S_WR_CTR;
            S_WR_CTR:  state_d = S_WR_STR;
            S_WR_STR: begin
                state_d = (str_q[5:0] == old_str_q) ? S_FINISH : S_POLL_LO;
            end
            S_POLL_LO: begin
                tmo_d = tmo_q + CW'(1);
                if (tmo_q == TMO_LAST) begin
                    state_d = S_ERROR;
                end else if (!bus_rdata_i[2]) begin
                    state_d = S_POLL_HI;
                end
            end
            S_POLL_HI: begin
                tmo_d = tmo_q + CW'(1);
                if (bus_rdata_i[2]) begin
                    state_d = S_FINISH;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_ERROR;
                end
            end
            S_WR_STD: state_d = S_FINISH;
            S_FINISH: state_d = S_IDLE;
            S_ERROR:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        unique case (state_d)
            S_RD_STR: begin
                rd_d   = 1'b1;
                addr_d = 3'd0;
            end
            S_WR_LDVR: begin
                wr_d    = 1'b1;
                addr_d  = 3'd1;
                wdata_d = div_q[7:0];
            end
            S_WR_UDVR: begin
                wr_d    = 1'b1;
                addr_d  = 3'd2;
                wdata_d = div_q[15:8];
            end
            S_WR_FSR: begin
                wr_d    = 1'b1;
                addr_d  = 3'd3;
                wdata_d = {2'b00, thr_q};
            end
            S_WR_ISR: begin
                wr_d    = 1'b1;
                addr_d  = 3'd5;
                wdata_d = {1'b0, ien_q, 3'b000};
            end
            S_WR_CTR: begin
                wr_d    = 1'b1;
                addr_d  = 3'd4;
                wdata_d = {1'b0, ive_q, 1'b0, cmode_q, 1'b1, 2'b00};
            end
            S_WR_STR: begin
                wr_d    = 1'b1;
                addr_d  = 3'd0;
                wdata_d = str_q;
            end
            S_POLL_LO, S_POLL_HI: begin
                rd_d   = 1'b1;
                addr_d = 3'd4;
            end
            S_WR_STD: begin
                wr_d    = 1'b1;
                addr_d  = 3'd4;
                wdata_d = 8'h02;
            end
            default: begin
            end
        endcase

        busy_d = !(state_d inside {S_IDLE, S_FINISH, S_ERROR});
        done_d = (state_d == S_FINISH) || (state_d == S_ERROR);
        err_d  = (state_d == S_ERROR);
    end

    // State, latched configuration and registered outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= S_IDLE;
            tmo_q     <= '0;
            old_str_q <= '0;
            str_q     <= '0;
            div_q     <= '0;
            thr_q     <= '0;
            ien_q     <= '0;
            ive_q     <= 1'b0;
            cmode_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            addr_q    <= 3'd4;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            tmo_q     <= tmo_d;
            old_str_q <= old_str_d;
            str_q     <= str_d;
            div_q     <= div_d;
            thr_q     <= thr_d;
            ien_q     <= ien_d;
            ive_q     <= ive_d;
            cmode_q   <= cmode_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign error_o       = err_q;
    assign bus_write_o   = wr_q;
    assign bus_read_o    = rd_q;
    assign bus_address_o = addr_q;
    assign bus_wdata_o   = wdata_q;

endmodule

// File: tb/tb_uart_config_sequencer.sv
// tb_uart_config_sequencer: directed and randomized sequences checked
// cycle by cycle against a transaction-list reference model.
module tb_uart_config_sequencer;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        use_std = 1'b0;
    logic [1:0]  wid = '0, par = '0, stp = '0, dsm = '0;
    logic [15:0] div = '0;
    logic [5:0]  thr = '0;
    logic [3:0]  ien = '0;
    logic        ive = 1'b0;
    logic [1:0]  cm = '0;
    logic [7:0]  rdata = '0;
    logic        busy_o, done_o, error_o, wr_o, rd_o;
    logic [2:0]  addr_o;
    logic [7:0]  wdata_o;

    always #5 clk = ~clk;

    uart_config_sequencer #(.TIMEOUT_CYCLES(T)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .use_std_i(use_std),
        .data_width_i(wid), .parity_mode_i(par), .stop_bits_i(stp),
        .dsm_i(dsm), .divisor_i(div), .rx_threshold_i(thr),
        .int_en_i(ien), .int_vec_en_i(ive), .comm_mode_i(cm),
        .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
        .bus_write_o(wr_o), .bus_read_o(rd_o), .bus_address_o(addr_o),
        .bus_wdata_o(wdata_o), .bus_rdata_i(rdata)
    );

    typedef struct {
        bit         rd;
        logic [2:0] a;
        logic [7:0] d;
    } op_t;

    op_t        eq[$];
    bit         exp_err;
    logic [7:0] ps [16];
    logic [2:0] last_a = 3'd4;
    int         nvec = 0;
    int         nerr = 0;

    function automatic op_t mk(bit rd, logic [2:0] a, logic [7:0] d);
        op_t o;
        o.rd = rd;
        o.a  = a;
        o.d  = d;
        return o;
    endfunction

    function automatic logic [15:0] obs();
        return {busy_o, done_o, error_o, wr_o, rd_o, addr_o,
                wr_o ? wdata_o : 8'h00};
    endfunction

    function automatic logic [15:0] obs_raw();
        return {busy_o, done_o, error_o, wr_o, rd_o, addr_o, wdata_o};
    endfunction

    task automatic chk(string tag, logic [15:0] o, logic [15:0] e);
        nvec++;
        assert (o === e) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_cfg();
        wid = 2'($urandom);
        par = 2'($urandom);
        stp = 2'($urandom);
        dsm = 2'($urandom);
        div = 16'($urandom);
        thr = 6'($urandom);
        ien = 4'($urandom);
        ive = 1'($urandom);
        cm  = 2'($urandom);
    endtask

    task automatic fill_ps(logic [7:0] b2);
        for (int j = 0; j < 16; j++)
            ps[j] = (8'($urandom) & 8'hfb) | b2;
    endtask

    // Expected bus transactions from the register map and poll script.
    task automatic build(bit std, logic [7:0] old);
        logic [7:0] ns;
        int i0, i1, n;
        eq.delete();
        exp_err = 1'b0;
        if (std) begin
            eq.push_back(mk(1'b0, 3'd4, 8'h02));
            return;
        end
        ns = {dsm, stp, par, wid};
        eq.push_back(mk(1'b1, 3'd0, old));
        eq.push_back(mk(1'b0, 3'd1, div[7:0]));
        eq.push_back(mk(1'b0, 3'd2, div[15:8]));
        eq.push_back(mk(1'b0, 3'd3, {2'b00, thr}));
        eq.push_back(mk(1'b0, 3'd5, {1'b0, ien, 3'b000}));
        eq.push_back(mk(1'b0, 3'd4, {1'b0, ive, 1'b0, cm, 1'b1, 2'b00}));
        eq.push_back(mk(1'b0, 3'd0, ns));
        if (ns[5:0] == old[5:0]) return;
        i0 = -1;
        i1 = -1;
        for (int j = 0; j < T; j++) begin
            if (i0 < 0) begin
                if (!ps[j][2]) i0 = j;
            end else if (i1 < 0 && ps[j][2]) begin
                i1 = j;
            end
        end
        n = (i1 >= 0) ? i1 + 1 : T;
        exp_err = (i1 < 0);
        for (int j = 0; j < n; j++)
            eq.push_back(mk(1'b1, 3'd4, ps[j]));
    endtask

    task automatic run_seq(string tag, bit std, logic [7:0] old,
                           int abort_at, bit pulse);
        build(std, old);
        use_std = std;
        start = 1'b1;
        step();
        start = 1'b0;
        rand_cfg();
        use_std = 1'($urandom);
        for (int c = 0; c < eq.size(); c++) begin
            chk($sformatf("%s_c%0d", tag, c + 1), obs(),
                {3'b100, !eq[c].rd, eq[c].rd, eq[c].a,
                 eq[c].rd ? 8'h00 : eq[c].d});
            last_a = eq[c].a;
            rdata = eq[c].rd ? eq[c].d : 8'($urandom);
            if (c == 0) start = pulse;
            if (c == 1) start = 1'b0;
            if (c + 1 == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk({tag, "_rst"}, obs_raw(), {5'b00000, 3'd4, 8'h00});
                start = 1'b0;
                repeat (2) step();
                rst_n = 1'b1;
                step();
                chk({tag, "_post"}, obs_raw(), {5'b00000, 3'd4, 8'h00});
                last_a = 3'd4;
                return;
            end
            step();
        end
        start = 1'b0;
        chk({tag, "_done"}, obs(), {2'b01, exp_err, 2'b00, last_a, 8'h00});
        step();
        chk({tag, "_idle"}, obs(), {5'b00000, last_a, 8'h00});
    endtask

    initial begin
        logic [7:0] old;
        repeat (3) step();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("reset_c%0d", i), obs_raw(),
                {5'b00000, 3'd4, 8'h00});
        end

        rand_cfg();
        {dsm, stp, par, wid} = 8'h03;
        div = 16'h0144;
        fill_ps(8'h04);
        run_seq("nochg", 1'b0, 8'h03, 0, 1'b0);

        rand_cfg();
        {dsm, stp, par, wid} = 8'h02;
        div = 16'h0144;
        fill_ps(8'h04);
        ps[1] = 8'h00; ps[2] = 8'h00; ps[3] = 8'h00;
        run_seq("nego", 1'b0, 8'h03, 0, 1'b0);

        rand_cfg();
        {dsm, stp, par, wid} = 8'h02;
        fill_ps(8'h04);
        run_seq("tmo", 1'b0, 8'h03, 0, 1'b0);

        rand_cfg();
        {dsm, stp, par, wid} = 8'h02;
        fill_ps(8'h04);
        ps[5] = 8'h00; ps[6] = 8'h00;
        run_seq("edge", 1'b0, 8'h03, 0, 1'b0);

        rand_cfg();
        run_seq("std", 1'b1, 8'h00, 0, 1'b1);

        rand_cfg();
        {dsm, stp, par, wid} = 8'h01;
        fill_ps(8'h00);
        run_seq("abort", 1'b0, 8'h03, 10, 1'b0);
        {dsm, stp, par, wid} = 8'h01;
        ps[0] = 8'h00; ps[1] = 8'h04;
        run_seq("replay", 1'b0, 8'h03, 0, 1'b0);

        for (int r = 0; r < 30; r++) begin
            rand_cfg();
            old = 8'($urandom);
            if ($urandom_range(0, 2) == 0) old[5:0] = {stp, par, wid};
            for (int j = 0; j < 16; j++)
                ps[j] = (8'($urandom) & 8'hfb) |
                        (($urandom_range(0, 2) != 0) ? 8'h04 : 8'h00);
            if ($urandom_range(0, 4) == 0) fill_ps(8'h04);
            run_seq($sformatf("rnd%0d", r), ($urandom_range(0, 3) == 0),
                    old, 0, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
